// File: rtl/dmi_master.sv
// DTM-side DMI master: turns one DMI-register update into a DM request/response handshake, with sticky status and abort timeout.
// Latency: dmi_req_valid one cycle after dtm_req_valid; backpressure: holds the request until dmi_req_ready, then waits for dmi_rsp_valid.
module dmi_master #(
    parameter int ABITS   = 7,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             trst,
    input  logic             dtm_req_valid,
    input  logic [ABITS-1:0] dtm_req_addr,
    input  logic [31:0]      dtm_req_data,
    input  logic [1:0]       dtm_req_op,
    input  logic             dtm_dmireset,
    input  logic             dtm_dmihardreset,
    output logic [31:0]      dtm_rsp_data,
    output logic [1:0]       dtm_rsp_op,
    output logic             dtm_busy,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_rsp_valid,
    output logic             dmi_rsp_ready,
    input  logic [31:0]      dmi_rsp_data,
    input  logic [1:0]       dmi_rsp_op
);

    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_FAILED = 2'd2;
    localparam logic [1:0] ST_BUSY   = 2'd3;

    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef struct packed {
        logic [ABITS-1:0] addr;
        logic [31:0]      data;
        logic [1:0]       op;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } state_t;

    state_t          state;
    req_t            req_lat;
    logic [1:0]      sticky;
    logic [CW-1:0]   cnt;

    logic [1:0]      sticky_clr;
    logic [1:0]      sticky_nxt;
    logic            start;
    logic            req_fire;
    logic            rsp_fire;
    logic            timeout_abort;

    assign dtm_rsp_op   = sticky;
    assign dmi_req_addr = req_lat.addr;
    assign dmi_req_data = req_lat.data;
    assign dmi_req_op   = req_lat.op;

    always_comb begin
        sticky_clr    = dtm_dmireset ? ST_OK : sticky;
        start         = (state == IDLE) && dtm_req_valid && (sticky_clr == ST_OK) &&
                        ((dtm_req_op == OP_READ) || (dtm_req_op == OP_WRITE));
        req_fire      = (state == REQ) && dmi_req_ready;
        rsp_fire      = (state == WAIT_RSP) && dmi_rsp_valid;
        // A response landing on the last allowed cycle still completes normally.
        timeout_abort = (TIMEOUT != 0) && (state != IDLE) && !rsp_fire &&
                        (cnt == TO_LAST[CW-1:0]);
        sticky_nxt    = sticky_clr;
        if (sticky_clr == ST_OK) begin
            if ((rsp_fire && (dmi_rsp_op != 2'd0)) || timeout_abort) begin
                sticky_nxt = ST_FAILED;
            end else if ((state != IDLE) && dtm_req_valid) begin
                sticky_nxt = ST_BUSY;
            end
        end
    end

    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            state         <= IDLE;
            req_lat       <= '0;
            sticky        <= ST_OK;
            cnt           <= '0;
            dtm_rsp_data  <= '0;
            dtm_busy      <= 1'b0;
            dmi_req_valid <= 1'b0;
            dmi_rsp_ready <= 1'b0;
        end else if (dtm_dmihardreset) begin
            state         <= IDLE;
            sticky        <= ST_OK;
            cnt           <= '0;
            dtm_busy      <= 1'b0;
            dmi_req_valid <= 1'b0;
            dmi_rsp_ready <= 1'b0;
        end else begin
            sticky <= sticky_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        req_lat       <= '{addr: dtm_req_addr, data: dtm_req_data, op: dtm_req_op};
                        cnt           <= '0;
                        state         <= REQ;
                        dtm_busy      <= 1'b1;
                        dmi_req_valid <= 1'b1;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (timeout_abort) begin
                        state         <= IDLE;
                        dtm_busy      <= 1'b0;
                        dmi_req_valid <= 1'b0;
                    end else if (req_fire) begin
                        state         <= WAIT_RSP;
                        dmi_req_valid <= 1'b0;
                        dmi_rsp_ready <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    cnt <= cnt + 1'b1;
                    if (rsp_fire) begin
                        dtm_rsp_data  <= dmi_rsp_data;
                        state         <= IDLE;
                        dtm_busy      <= 1'b0;
                        dmi_rsp_ready <= 1'b0;
                    end else if (timeout_abort) begin
                        state         <= IDLE;
                        dtm_busy      <= 1'b0;
                        dmi_rsp_ready <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    dtm_busy      <= 1'b0;
                    dmi_req_valid <= 1'b0;
                    dmi_rsp_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_master.sv
// Scoreboard bench for dmi_master: DMI requests and DTM responses are queued when driven and popped when the DUT delivers them.
module tb_dmi_master;

    localparam int AB = 7;

    typedef struct packed {
        logic [AB-1:0] addr;
        logic [31:0]   data;
        logic [1:0]    op;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  op;
    } rsp_t;

    logic          clk = 1'b0;
    logic          trst;
    logic          dtm_req_valid;
    logic [AB-1:0] dtm_req_addr;
    logic [31:0]   dtm_req_data;
    logic [1:0]    dtm_req_op;
    logic          dtm_dmireset;
    logic          dtm_dmihardreset;
    logic [31:0]   dtm_rsp_data;
    logic [1:0]    dtm_rsp_op;
    logic          dtm_busy;
    logic          dmi_req_valid;
    logic          dmi_req_ready;
    logic [AB-1:0] dmi_req_addr;
    logic [31:0]   dmi_req_data;
    logic [1:0]    dmi_req_op;
    logic          dmi_rsp_valid;
    logic          dmi_rsp_ready;
    logic [31:0]   dmi_rsp_data;
    logic [1:0]    dmi_rsp_op;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          checks = 0;
    int          passed = 0;
    int          hs_cnt = 0;
    logic [31:0] last_data = 32'h0;

    always #5 clk = ~clk;

    dmi_master #(.ABITS(AB), .TIMEOUT(8)) dut (
        .clk(clk), .trst(trst),
        .dtm_req_valid(dtm_req_valid), .dtm_req_addr(dtm_req_addr),
        .dtm_req_data(dtm_req_data), .dtm_req_op(dtm_req_op),
        .dtm_dmireset(dtm_dmireset), .dtm_dmihardreset(dtm_dmihardreset),
        .dtm_rsp_data(dtm_rsp_data), .dtm_rsp_op(dtm_rsp_op), .dtm_busy(dtm_busy),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
        .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op)
    );

    always @(posedge clk) if (dmi_req_valid && dmi_req_ready) hs_cnt <= hs_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Drives a one-cycle DTM update; push=1 when the bench expects it to reach the DMI bus.
    task automatic issue(input logic [AB-1:0] a, input logic [31:0] d, input logic [1:0] o, input bit push);
        req_t e;
        dtm_req_valid = 1'b1;
        dtm_req_addr  = a;
        dtm_req_data  = d;
        dtm_req_op    = o;
        e.addr = a; e.data = d; e.op = o;
        if (push) req_q.push_back(e);
        tick();
        dtm_req_valid = 1'b0;
        dtm_req_op    = 2'd0;
    endtask

    task automatic dm_serve(input int delay, input logic [31:0] rdata, input logic [1:0] rop, input logic [1:0] exp_op);
        req_t e;
        rsp_t r;
        int   w;
        int   hs0;
        w = 0;
        while (dmi_req_valid !== 1'b1 && w < 20) begin tick(); w++; end
        checks++; if (dmi_req_valid !== 1'b1) $display("FAIL serve_req_valid: got %b want 1", dmi_req_valid); else passed++;
        e = (req_q.size() != 0) ? req_q.pop_front() : '0;
        for (int i = 0; i < delay; i++) begin
            checks++;
            if ({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op} !== {1'b1, e.addr, e.data, e.op})
                $display("FAIL serve_stable: got %b/%h/%h/%h want 1/%h/%h/%h", dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, e.addr, e.data, e.op);
            else passed++;
            tick();
        end
        hs0 = hs_cnt;
        dmi_req_ready = 1'b1;
        checks++;
        if ({dmi_req_addr, dmi_req_data, dmi_req_op} !== e)
            $display("FAIL serve_req_fields: got %h/%h/%h want %h/%h/%h", dmi_req_addr, dmi_req_data, dmi_req_op, e.addr, e.data, e.op);
        else passed++;
        tick();
        dmi_req_ready = 1'b0;
        checks++; if (hs_cnt - hs0 != 1) $display("FAIL serve_handshakes: got %0d want 1", hs_cnt - hs0); else passed++;
        w = 0;
        while (dmi_rsp_ready !== 1'b1 && w < 20) begin tick(); w++; end
        checks++; if (dmi_rsp_ready !== 1'b1) $display("FAIL serve_rsp_ready: got %b want 1", dmi_rsp_ready); else passed++;
        dmi_rsp_valid = 1'b1;
        dmi_rsp_data  = rdata;
        dmi_rsp_op    = rop;
        r.data = rdata; r.op = exp_op;
        rsp_q.push_back(r);
        last_data = rdata;
        tick();
        dmi_rsp_valid = 1'b0;
        dmi_rsp_data  = 32'h0;
        dmi_rsp_op    = 2'd0;
        checks++; if (dtm_busy !== 1'b0) $display("FAIL serve_done_busy: got %b want 0", dtm_busy); else passed++;
        r = rsp_q.pop_front();
        checks++;
        if ({dtm_rsp_data, dtm_rsp_op} !== {r.data, r.op})
            $display("FAIL serve_rsp: got %h/%0d want %h/%0d", dtm_rsp_data, dtm_rsp_op, r.data, r.op);
        else passed++;
    endtask

    task automatic test_reset();
        trst = 1'b0;
        dtm_req_valid = 0; dtm_req_addr = '0; dtm_req_data = '0; dtm_req_op = '0;
        dtm_dmireset = 0; dtm_dmihardreset = 0;
        dmi_req_ready = 0; dmi_rsp_valid = 0; dmi_rsp_data = '0; dmi_rsp_op = '0;
        repeat (2) tick();
        checks++;
        if ({dtm_rsp_data, dtm_rsp_op, dtm_busy, dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready} !== '0)
            $display("FAIL reset_outputs: got %h/%h/%b/%b/%h/%h/%h/%b want all 0", dtm_rsp_data, dtm_rsp_op, dtm_busy, dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready);
        else passed++;
        trst = 1'b1;
        tick();
    endtask

    task automatic test_read();
        req_t e;
        rsp_t r;
        issue(7'h11, 32'h0, 2'd1, 1);
        checks++; if ({dmi_req_valid, dtm_busy, dmi_rsp_ready} !== 3'b110) $display("FAIL read_n1: got v/b/r=%b%b%b want 110", dmi_req_valid, dtm_busy, dmi_rsp_ready); else passed++;
        dmi_req_ready = 1'b1;
        e = req_q.pop_front();
        checks++; if ({dmi_req_addr, dmi_req_data, dmi_req_op} !== e) $display("FAIL read_fields: got %h/%h/%h want %h/%h/%h", dmi_req_addr, dmi_req_data, dmi_req_op, e.addr, e.data, e.op); else passed++;
        tick();
        dmi_req_ready = 1'b0;
        checks++; if ({dmi_req_valid, dtm_busy, dmi_rsp_ready} !== 3'b011) $display("FAIL read_n2: got v/b/r=%b%b%b want 011", dmi_req_valid, dtm_busy, dmi_rsp_ready); else passed++;
        dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'h0000_0C82; dmi_rsp_op = 2'd0;
        r.data = 32'h0000_0C82; r.op = 2'd0; rsp_q.push_back(r); last_data = r.data;
        tick();
        dmi_rsp_valid = 1'b0; dmi_rsp_data = '0;
        checks++; if ({dtm_busy, dmi_rsp_ready} !== 2'b00) $display("FAIL read_n3: got b/r=%b%b want 00", dtm_busy, dmi_rsp_ready); else passed++;
        r = rsp_q.pop_front();
        checks++; if ({dtm_rsp_data, dtm_rsp_op} !== {r.data, r.op}) $display("FAIL read_rsp: got %h/%0d want %h/%0d", dtm_rsp_data, dtm_rsp_op, r.data, r.op); else passed++;
    endtask

    task automatic test_write_delayed();
        issue(7'h10, 32'h8000_0001, 2'd2, 1);
        dm_serve(4, 32'h0, 2'd0, 2'd0);
    endtask

    task automatic test_nop_ops();
        issue(7'h12, 32'h1111_1111, 2'd0, 0);
        checks++; if ({dtm_busy, dmi_req_valid, dtm_rsp_op} !== 4'b0000) $display("FAIL nop_op0: got b/v/op=%b%b%0d want 000", dtm_busy, dmi_req_valid, dtm_rsp_op); else passed++;
        issue(7'h13, 32'h2222_2222, 2'd3, 0);
        checks++; if ({dtm_busy, dmi_req_valid, dtm_rsp_op} !== 4'b0000) $display("FAIL nop_op3: got b/v/op=%b%b%0d want 000", dtm_busy, dmi_req_valid, dtm_rsp_op); else passed++;
        checks++; if (dtm_rsp_data !== last_data) $display("FAIL nop_data: got %h want %h", dtm_rsp_data, last_data); else passed++;
    endtask

    task automatic test_busy_sticky();
        rsp_t r;
        issue(7'h04, 32'h0, 2'd1, 1);
        dmi_req_ready = 1'b1;
        void'(req_q.pop_front());
        tick();
        dmi_req_ready = 1'b0;
        issue(7'h05, 32'h0, 2'd1, 0);
        checks++; if ({dtm_rsp_op, dtm_busy, dmi_rsp_ready} !== 4'b1111) $display("FAIL busy_sticky3: got op/b/r=%0d/%b/%b want 3/1/1", dtm_rsp_op, dtm_busy, dmi_rsp_ready); else passed++;
        dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'h0000_1234; dmi_rsp_op = 2'd0;
        r.data = 32'h0000_1234; r.op = 2'd3; rsp_q.push_back(r); last_data = r.data;
        tick();
        dmi_rsp_valid = 1'b0; dmi_rsp_data = '0;
        r = rsp_q.pop_front();
        checks++; if ({dtm_busy, dtm_rsp_data, dtm_rsp_op} !== {1'b0, r.data, r.op}) $display("FAIL busy_first_done: got %b/%h/%0d want 0/%h/%0d", dtm_busy, dtm_rsp_data, dtm_rsp_op, r.data, r.op); else passed++;
        issue(7'h06, 32'h0, 2'd1, 0);
        checks++; if ({dtm_busy, dmi_req_valid, dtm_rsp_op} !== 4'b0011) $display("FAIL busy_ignored: got b/v/op=%b%b%0d want 003", dtm_busy, dmi_req_valid, dtm_rsp_op); else passed++;
        dtm_dmireset = 1'b1;
        issue(7'h06, 32'h0, 2'd1, 1);
        dtm_dmireset = 1'b0;
        checks++; if ({dtm_busy, dtm_rsp_op} !== 3'b100) $display("FAIL busy_reset_accept: got b/op=%b/%0d want 1/0", dtm_busy, dtm_rsp_op); else passed++;
        dm_serve(1, 32'hCAFE_0006, 2'd0, 2'd0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            issue(AB'(i + 3), $urandom, (i % 2 == 1) ? 2'd2 : 2'd1, 1);
            dm_serve(i, $urandom, 2'd0, 2'd0);
        end
        issue(7'h20, 32'h0, 2'd1, 1);
        dm_serve(0, 32'hBAD0_0001, 2'd1, 2'd2);
        issue(7'h21, 32'h0, 2'd1, 0);
        checks++; if ({dtm_busy, dtm_rsp_op} !== 3'b010) $display("FAIL err_ignore: got b/op=%b/%0d want 0/2", dtm_busy, dtm_rsp_op); else passed++;
        dtm_dmireset = 1'b1;
        tick();
        dtm_dmireset = 1'b0;
        checks++; if ({dtm_busy, dtm_rsp_op} !== 3'b000) $display("FAIL err_clear: got b/op=%b/%0d want 0/0", dtm_busy, dtm_rsp_op); else passed++;
    endtask

    task automatic test_timeout();
        issue(7'h30, 32'h0, 2'd1, 0);
        for (int k = 1; k <= 8; k++) begin
            checks++; if ({dtm_busy, dmi_req_valid} !== 2'b11) $display("FAIL timeout_busy_c%0d: got b/v=%b%b want 11", k, dtm_busy, dmi_req_valid); else passed++;
            tick();
        end
        checks++; if ({dtm_busy, dmi_req_valid, dmi_rsp_ready, dtm_rsp_op} !== 5'b00010) $display("FAIL timeout_abort: got b/v/r/op=%b%b%b/%0d want 000/2", dtm_busy, dmi_req_valid, dmi_rsp_ready, dtm_rsp_op); else passed++;
        dtm_dmireset = 1'b1;
        tick();
        dtm_dmireset = 1'b0;
    endtask

    task automatic test_hardreset();
        issue(7'h08, 32'h0, 2'd1, 1);
        dmi_req_ready = 1'b1;
        void'(req_q.pop_front());
        tick();
        dmi_req_ready = 1'b0;
        issue(7'h09, 32'h0, 2'd1, 0);
        checks++; if (dtm_rsp_op !== 2'd3) $display("FAIL hard_pre_sticky: got %0d want 3", dtm_rsp_op); else passed++;
        dtm_dmihardreset = 1'b1;
        tick();
        dtm_dmihardreset = 1'b0;
        checks++; if ({dtm_busy, dmi_rsp_ready, dtm_rsp_op} !== 4'b0000) $display("FAIL hard_idle: got b/r/op=%b%b/%0d want 00/0", dtm_busy, dmi_rsp_ready, dtm_rsp_op); else passed++;
        dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'hDEAD_BEEF;
        tick();
        dmi_rsp_valid = 1'b0; dmi_rsp_data = '0;
        checks++; if ({dtm_busy, dtm_rsp_data} !== {1'b0, last_data}) $display("FAIL hard_late_rsp: got %b/%h want 0/%h", dtm_busy, dtm_rsp_data, last_data); else passed++;
        dtm_dmihardreset = 1'b1;
        issue(7'h0A, 32'h0, 2'd1, 0);
        dtm_dmihardreset = 1'b0;
        checks++; if ({dtm_busy, dmi_req_valid} !== 2'b00) $display("FAIL hard_drop_req: got b/v=%b%b want 00", dtm_busy, dmi_req_valid); else passed++;
    endtask

    task automatic test_trst_midflight();
        int hs0;
        issue(7'h15, 32'h1357_9BDF, 2'd2, 1);
        checks++; if (dmi_req_valid !== 1'b1) $display("FAIL trst_pre_valid: got %b want 1", dmi_req_valid); else passed++;
        #2 trst = 1'b0;
        #1;
        checks++;
        if ({dtm_rsp_data, dtm_rsp_op, dtm_busy, dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready} !== '0)
            $display("FAIL trst_outputs: got %h/%h/%b/%b/%h/%h/%h/%b want all 0", dtm_rsp_data, dtm_rsp_op, dtm_busy, dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready);
        else passed++;
        hs0 = hs_cnt;
        dmi_req_ready = 1'b1;
        repeat (2) tick();
        dmi_req_ready = 1'b0;
        checks++; if (hs_cnt != hs0) $display("FAIL trst_no_handshake: got %0d want 0", hs_cnt - hs0); else passed++;
        req_q.delete();
        trst = 1'b1;
        tick();
        issue(7'h16, 32'h0, 2'd1, 1);
        dm_serve(0, 32'hA5A5_5A5A, 2'd0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_delayed();
        test_nop_ops();
        test_busy_sticky();
        test_back_to_back();
        test_timeout();
        test_hardreset();
        test_trst_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
